// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: converts a single-beat command/response interface into one
// AXI4-Lite read or write transaction at a time, in order, one outstanding.
module axi_lite_cmd_master #(
    parameter int unsigned C_ADDR_W   = 16,
    parameter int unsigned C_ERRCNT_W = 8
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_areset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [C_ADDR_W-1:0]   cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [C_ERRCNT_W-1:0] err_cnt,
    output logic                  busy,

    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [C_ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,

    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,

    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    input  logic [1:0]            m_axi_bresp,

    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [C_ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]            m_axi_arprot,

    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp
);

    typedef enum logic [2:0] {
        StIdle,
        StWrAddrData,
        StWrResp,
        StRdAddr,
        StRdData,
        StRsp
    } state_e;

    state_e                state_q, state_d;
    logic [C_ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  write_q, write_d;
    // AW and W complete independently; each pending flag is that channel's valid.
    logic                  aw_pend_q, aw_pend_d;
    logic                  w_pend_q, w_pend_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic [C_ERRCNT_W-1:0] err_q, err_d;
    logic                  capture;

    // Next-state, command latch, response capture and error counting.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        write_d   = write_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        err_d     = err_q;
        capture   = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    write_d = cmd_write;
                    if (cmd_write) begin
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                        state_d   = StWrAddrData;
                    end else begin
                        state_d = StRdAddr;
                    end
                end
            end
            StWrAddrData: begin
                if (aw_pend_q && m_axi_awready) aw_pend_d = 1'b0;
                if (w_pend_q && m_axi_wready)   w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d)    state_d   = StWrResp;
            end
            StWrResp: begin
                if (m_axi_bvalid) begin
                    resp_d  = m_axi_bresp;
                    rdata_d = 32'h0;
                    capture = 1'b1;
                    state_d = StRsp;
                end
            end
            StRdAddr: begin
                if (m_axi_arready) state_d = StRdData;
            end
            StRdData: begin
                if (m_axi_rvalid) begin
                    resp_d  = m_axi_rresp;
                    rdata_d = m_axi_rdata;
                    capture = 1'b1;
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (capture && (resp_d != 2'b00) && (err_q != {C_ERRCNT_W{1'b1}})) begin
            err_d = err_q + 1'b1;
        end
    end

    // State and datapath registers; async reset drops every valid immediately.
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            write_q   <= write_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            err_q     <= err_d;
        end
    end

    // Outputs are decoded from registered state only, never from readies.
    always_comb begin
        cmd_ready     = (state_q == StIdle);
        busy          = (state_q != StIdle);
        rsp_valid     = (state_q == StRsp);
        rsp_write     = write_q;
        rsp_rdata     = rdata_q;
        rsp_resp      = resp_q;
        err_cnt       = err_q;
        m_axi_awvalid = aw_pend_q;
        m_axi_awaddr  = addr_q;
        m_axi_awprot  = 3'b000;
        m_axi_wvalid  = w_pend_q;
        m_axi_wdata   = wdata_q;
        m_axi_wstrb   = wstrb_q;
        m_axi_bready  = (state_q == StWrResp);
        m_axi_arvalid = (state_q == StRdAddr);
        m_axi_araddr  = addr_q;
        m_axi_arprot  = 3'b000;
        m_axi_rready  = (state_q == StRdData);
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Randomized bench for axi_lite_cmd_master: a behavioural AXI4-Lite slave with random
// stalls and responses, and a transaction-level model of memory and error count.
module tb_axi_lite_cmd_master;

    localparam int ERR_MAX = 255;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_cnt;
    logic        busy;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axi_lite_cmd_master #(.C_ADDR_W(16), .C_ERRCNT_W(8)) dut (
        .m_axi_aclk    (clk),
        .m_axi_areset  (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_write     (rsp_write),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .err_cnt       (err_cnt),
        .busy          (busy),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_bresp   (bresp),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp)
    );

    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  resp;
    } txn_t;

    int          n_cmp = 0;
    int          n_err = 0;
    txn_t        slv_q[$];
    logic [31:0] slv_mem[16];
    logic [31:0] model_mem[16];
    int          exp_err;
    int          mode;  // 0 random stalls, 1 readies tied high, 2 readies held low

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // ---------------- behavioural slave ----------------
    logic        aw_got, w_got, b_pend, r_pend;
    int          b_dly, r_dly;
    logic [15:0] aw_addr_c, aw_prev, ar_prev;
    logic [31:0] w_data_c, w_prev;
    logic [3:0]  w_strb_c;
    logic [3:0]  ar_idx;
    logic        aw_wait, w_wait, ar_wait;
    txn_t        cur;

    task automatic slv_clear();
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_dly = 0; r_dly = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 2'b00; rresp = 2'b00; rdata = 32'h0;
        slv_q.delete();
    endtask

    initial begin
        slv_clear();
        forever begin
            @(negedge clk);
            if (rst) begin
                slv_clear();
                continue;
            end
            cur = (slv_q.size() > 0) ? slv_q[0] : '0;
            case (mode)
                1: begin awready = 1; wready = 1; arready = 1; end
                2: begin awready = 0; wready = 0; arready = 0; end
                default: begin
                    awready = 1'($urandom_range(0, 1));
                    wready  = 1'($urandom_range(0, 1));
                    arready = 1'($urandom_range(0, 1));
                end
            endcase
            bvalid = b_pend && (b_dly == 0);
            bresp  = bvalid ? cur.resp : 2'($urandom);
            if (b_pend && b_dly > 0) b_dly--;
            rvalid = r_pend && (r_dly == 0);
            rresp  = rvalid ? cur.resp : 2'($urandom);
            rdata  = rvalid ? slv_mem[ar_idx] : $urandom;
            if (r_pend && r_dly > 0) r_dly--;

            #2;
            if (rst) begin
                slv_clear();
                continue;
            end
            // valids must persist with stable payload until their handshake
            if (aw_wait) begin
                check_eq("aw_hold", 64'(awvalid), 64'd1);
                check_eq("aw_addr_stable", 64'(awaddr), 64'(aw_prev));
            end
            if (w_wait) begin
                check_eq("w_hold", 64'(wvalid), 64'd1);
                check_eq("w_data_stable", 64'(wdata), 64'(w_prev));
            end
            if (ar_wait) begin
                check_eq("ar_hold", 64'(arvalid), 64'd1);
                check_eq("ar_addr_stable", 64'(araddr), 64'(ar_prev));
            end
            aw_wait = awvalid && !awready; aw_prev = awaddr;
            w_wait  = wvalid && !wready;   w_prev  = wdata;
            ar_wait = arvalid && !arready; ar_prev = araddr;

            if (awvalid && awready) begin
                check_eq("aw_once", 64'(aw_got), 64'd0);
                check_eq("awaddr", 64'(awaddr), 64'(cur.addr));
                check_eq("awprot", 64'(awprot), 64'd0);
                aw_got = 1; aw_addr_c = awaddr;
            end
            if (wvalid && wready) begin
                check_eq("w_once", 64'(w_got), 64'd0);
                check_eq("wdata", 64'(wdata), 64'(cur.wdata));
                check_eq("wstrb", 64'(wstrb), 64'(cur.wstrb));
                w_got = 1; w_data_c = wdata; w_strb_c = wstrb;
            end
            if (bready) check_eq("bready_early", 64'(aw_got && w_got), 64'd1);
            if (aw_got && w_got && !b_pend) begin
                slv_mem[aw_addr_c[5:2]] = merge(slv_mem[aw_addr_c[5:2]], w_data_c, w_strb_c);
                b_pend = 1;
                b_dly  = (mode == 0) ? $urandom_range(0, 3) : 0;
            end
            if (bvalid && bready) begin
                b_pend = 0; aw_got = 0; w_got = 0;
                if (slv_q.size() > 0) void'(slv_q.pop_front());
            end
            if (arvalid && arready) begin
                check_eq("araddr", 64'(araddr), 64'(cur.addr));
                check_eq("arprot", 64'(arprot), 64'd0);
                ar_idx = araddr[5:2];
                r_pend = 1;
                r_dly  = (mode == 0) ? $urandom_range(0, 4) : 0;
            end
            if (rvalid && rready) begin
                r_pend = 0;
                if (slv_q.size() > 0) void'(slv_q.pop_front());
            end
        end
    end

    // ---------------- command driver and reference model ----------------
    task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [1:0] rsp, input int hold,
                          input bit chk_lat);
        txn_t        t;
        logic [31:0] exp_rd;
        int          lat;
        bit          ok;
        t = '{write: wr, addr: addr, wdata: wd, wstrb: ws, resp: rsp};
        slv_q.push_back(t);
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            #2;
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        check_eq("cmd_accept", 64'(ok), 64'd1);
        @(negedge clk);
        // scramble the command bus so the DUT must use its latched copy
        cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = 16'($urandom);
        cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        if (!ok) return;
        exp_rd = wr ? 32'h0 : model_mem[addr[5:2]];
        lat = 1; ok = 0;
        for (int i = 0; i < 200; i++) begin
            #2;
            if (rsp_valid) begin ok = 1; break; end
            check_eq("cmd_ready_busy", 64'(cmd_ready), 64'd0);
            @(negedge clk);
            lat++;
        end
        check_eq("rsp_seen", 64'(ok), 64'd1);
        if (!ok) return;
        if (chk_lat) check_eq("latency", 64'(lat), 64'd3);
        check_eq("rsp_write", 64'(rsp_write), 64'(wr));
        check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        check_eq("rsp_resp", 64'(rsp_resp), 64'(rsp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #2;
            check_eq("hold_valid", 64'(rsp_valid), 64'd1);
            check_eq("hold_rdata", 64'(rsp_rdata), 64'(exp_rd));
            check_eq("hold_resp", 64'(rsp_resp), 64'(rsp));
            check_eq("hold_write", 64'(rsp_write), 64'(wr));
            check_eq("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            check_eq("hold_axi_idle", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        if (wr) model_mem[addr[5:2]] = merge(model_mem[addr[5:2]], wd, ws);
        if (rsp != 2'b00 && exp_err < ERR_MAX) exp_err++;
        #2;
        check_eq("cmd_ready_after", 64'(cmd_ready), 64'd1);
        check_eq("rsp_valid_after", 64'(rsp_valid), 64'd0);
        check_eq("err_cnt", 64'(err_cnt), 64'(exp_err));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        check_eq({tag, "_rsp_resp"}, 64'(rsp_resp), 64'd0);
        check_eq({tag, "_rsp_write"}, 64'(rsp_write), 64'd0);
        check_eq({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
        check_eq({tag, "_axi"}, 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    endtask

    initial begin
        logic        wr;
        logic [1:0]  rsp;
        logic [15:0] addr;
        txn_t        t;
        rst = 1; mode = 1; exp_err = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i]   = $urandom;
            model_mem[i] = slv_mem[i];
        end
        repeat (3) @(negedge clk);
        rst = 0;
        #2;
        check_idle_outputs("reset");

        // directed: write 3 to 0x0004 with readies high, response held 10 cycles
        do_txn(1'b1, 16'h0004, 32'h0000_0003, 4'hF, 2'b00, 10, 1'b1);
        do_txn(1'b0, 16'h0004, 32'h0, 4'h0, 2'b00, 0, 1'b1);
        do_txn(1'b1, 16'h0008, 32'h0000_0005, 4'hF, 2'b00, 0, 1'b1);

        // random traffic with random stalls and error responses
        mode = 0;
        do_txn(1'b0, 16'h0008, 32'h0, 4'h0, 2'b00, 0, 1'b0);
        for (int n = 0; n < 200; n++) begin
            wr   = 1'($urandom_range(0, 1));
            rsp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            addr = 16'($urandom) & 16'hFFFC;
            do_txn(wr, addr, $urandom, 4'($urandom), rsp, $urandom_range(0, 3), 1'b0);
        end

        // SLVERR storm drives the error counter into saturation
        mode = 1;
        for (int n = 0; n < 300; n++) begin
            addr = 16'($urandom) & 16'hFFFC;
            do_txn(1'b1, addr, $urandom, 4'($urandom), 2'b10, 0, 1'b1);
        end
        check_eq("err_saturated", 64'(err_cnt), 64'hFF);

        // reset while both AW and W are stalled
        mode = 2;
        t = '{write: 1'b1, addr: 16'h0010, wdata: 32'hA5A5_5A5A, wstrb: 4'hF, resp: 2'b00};
        slv_q.push_back(t);
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = t.addr; cmd_wdata = t.wdata; cmd_wstrb = 4'hF;
        #2;
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 0;
        #2;
        check_eq("rst_awvalid_pre", 64'(awvalid), 64'd1);
        check_eq("rst_wvalid_pre", 64'(wvalid), 64'd1);
        #1 rst = 1;
        #1;
        check_eq("rst_awvalid_async", 64'(awvalid), 64'd0);
        check_eq("rst_wvalid_async", 64'(wvalid), 64'd0);
        check_eq("rst_busy_async", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst = 0; exp_err = 0;
        #2;
        check_idle_outputs("post_rst");
        mode = 0;
        do_txn(1'b1, 16'h0020, 32'h1234_5678, 4'h3, 2'b01, 1, 1'b0);
        do_txn(1'b0, 16'h0020, 32'h0, 4'h0, 2'b00, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
